// File: rtl/clock_period_meter.sv
// Measures the rising-edge-to-rising-edge period of a slow asynchronous square wave in clk_50Mhz
// cycles, derives the matching half-period divider terminal count and flags lock and loss of signal.
// Optional high-time measurement is enabled by defining MEAS_HIGH_TIME_EN.
module clock_period_meter #(
  parameter logic [31:0] TIMEOUT    = 32'd100000000,
  parameter int          LOCK_COUNT = 4,
  parameter logic [31:0] MATCH_TOL  = 32'd1
) (
  input  logic        clk_50Mhz,
  input  logic        reset,
  input  logic        sig_in,
  output logic [31:0] period,
  output logic [31:0] expire_est,
  output logic        meas_valid,
  output logic        locked,
  output logic        timeout,
  output logic [31:0] high_cycles
);

  localparam int              RUN_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [31:0]      cnt;
  logic [RUN_W-1:0] run;

  logic             rise;
  logic [31:0]      new_period;
  logic [31:0]      new_expire;
  logic [31:0]      diff;
  logic [RUN_W-1:0] run_next;
  logic             lock_next;
  logic             do_meas;
  logic             do_first;
  logic             do_timeout;

  assign rise       = s2 & ~s3;
  assign new_period = cnt + 32'd1;
  assign new_expire = (new_period < 32'd2) ? 32'd0 : ((new_period >> 1) - 32'd1);
  assign diff       = (new_period > period) ? (new_period - period) : (period - new_period);

  // A rise on the timeout cycle is still a valid measurement, so timeout requires no rise.
  assign do_meas    = (state == MEASURE) && rise;
  assign do_first   = (state == IDLE) && rise;
  assign do_timeout = (state == MEASURE) && !rise && (new_period == TIMEOUT);

  // run == 0 means no reference period since the last reset or signal loss.
  always_comb begin
    run_next  = RUN_ONE;
    lock_next = 1'b0;
    if (run == '0) begin
      run_next  = RUN_ONE;
      lock_next = (RUN_ONE == RUN_MAX);
    end else if (diff <= MATCH_TOL) begin
      run_next  = (run == RUN_MAX) ? run : (run + RUN_ONE);
      lock_next = (run_next == RUN_MAX);
    end
  end

  always_ff @(posedge clk_50Mhz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= 32'd0;
      run        <= '0;
      period     <= 32'd0;
      expire_est <= 32'd0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 32'd0;
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (do_meas) begin
            period     <= new_period;
            expire_est <= new_expire;
            meas_valid <= 1'b1;
            run        <= run_next;
            locked     <= lock_next;
            cnt        <= 32'd0;
          end else if (do_timeout) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            run     <= '0;
            cnt     <= 32'd0;
            state   <= IDLE;
          end else begin
            cnt <= new_period;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEAS_HIGH_TIME_EN
  logic [31:0] hcnt;

  // The rise cycle itself has s2 high, so a new count starts at 1.
  always_ff @(posedge clk_50Mhz or negedge reset) begin
    if (!reset) begin
      hcnt        <= 32'd0;
      high_cycles <= 32'd0;
    end else if (do_meas) begin
      high_cycles <= hcnt;
      hcnt        <= 32'd1;
    end else if (do_first) begin
      hcnt <= 32'd1;
    end else if (do_timeout) begin
      hcnt        <= 32'd0;
      high_cycles <= 32'd0;
    end else if (state == MEASURE) begin
      hcnt <= hcnt + {31'd0, s2};
    end
  end
`else
  assign high_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: a table of square-wave segments with end-of-segment
// expectations, plus a hand-written asynchronous reset sequence.
module tb_clock_period_meter;

  logic        clk_50Mhz = 1'b0;
  logic        reset     = 1'b0;
  logic        sig_in    = 1'b0;
  logic [31:0] period;
  logic [31:0] expire_est;
  logic        meas_valid;
  logic        locked;
  logic        timeout;
  logic [31:0] high_cycles;

  clock_period_meter #(
    .TIMEOUT   (32'd1000),
    .LOCK_COUNT(4),
    .MATCH_TOL (32'd1)
  ) dut (
    .clk_50Mhz  (clk_50Mhz),
    .reset      (reset),
    .sig_in     (sig_in),
    .period     (period),
    .expire_est (expire_est),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout),
    .high_cycles(high_cycles)
  );

  always #5 clk_50Mhz = ~clk_50Mhz;

  typedef struct {
    int high;
    int low;
    int n_valid;
    int per;
    int exp;
    int lk;
    int n_to;
    int hc;
  } seg_t;

  seg_t tbl[18];
  int   checks   = 0;
  int   failures = 0;
  int   n_valid, n_to, n_both;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_50Mhz);
    #1;
    if (meas_valid) n_valid++;
    if (timeout) n_to++;
    if (meas_valid && timeout) n_both++;
  endtask

  task automatic run_seg(input int idx, input seg_t s);
    int exp_hc;
`ifdef MEAS_HIGH_TIME_EN
    exp_hc = s.hc;
`else
    exp_hc = 0;
`endif
    n_valid = 0;
    n_to    = 0;
    n_both  = 0;
    sig_in  = 1'b1;
    for (int i = 0; i < s.high; i++) tick();
    sig_in = 1'b0;
    for (int i = 0; i < s.low; i++) tick();
    chk($sformatf("seg%0d_valid_pulses", idx), n_valid, s.n_valid);
    chk($sformatf("seg%0d_timeout_pulses", idx), n_to, s.n_to);
    chk($sformatf("seg%0d_overlap", idx), n_both, 0);
    chk($sformatf("seg%0d_period", idx), period, s.per);
    chk($sformatf("seg%0d_expire_est", idx), expire_est, s.exp);
    chk($sformatf("seg%0d_locked", idx), {31'd0, locked}, s.lk);
    chk($sformatf("seg%0d_high_cycles", idx), high_cycles, exp_hc);
    $display("seg%0d high=%0d low=%0d valid=%0d to=%0d period=%0d expire=%0d locked=%0d high_cycles=%0d",
             idx, s.high, s.low, n_valid, n_to, period, expire_est, locked, high_cycles);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_expire_est"}, expire_est, 0);
    chk({tag, "_meas_valid"}, {31'd0, meas_valid}, 0);
    chk({tag, "_locked"}, {31'd0, locked}, 0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 0);
    chk({tag, "_high_cycles"}, high_cycles, 0);
  endtask

  initial begin
    //          high  low  valid period expire lock to  high_cycles
    tbl[0]  = '{5,    5,    0,   0,     0,     0,   0,  0};
    tbl[1]  = '{5,    5,    1,   10,    4,     0,   0,  5};
    tbl[2]  = '{5,    5,    1,   10,    4,     0,   0,  5};
    tbl[3]  = '{5,    5,    1,   10,    4,     0,   0,  5};
    tbl[4]  = '{5,    5,    1,   10,    4,     1,   0,  5};
    tbl[5]  = '{7,    7,    1,   10,    4,     1,   0,  5};
    tbl[6]  = '{7,    6,    1,   14,    6,     0,   0,  7};
    tbl[7]  = '{5,    5,    1,   13,    5,     0,   0,  7};
    tbl[8]  = '{3,    1100, 1,   10,    4,     0,   1,  0};
    tbl[9]  = '{5,    5,    0,   10,    4,     0,   0,  0};
    tbl[10] = '{5,    5,    1,   10,    4,     0,   0,  5};
    tbl[11] = '{500,  500,  1,   10,    4,     0,   0,  5};
    tbl[12] = '{5,    5,    1,   1000,  499,   0,   0,  500};
    tbl[13] = '{500,  501,  1,   10,    4,     0,   0,  5};
    tbl[14] = '{5,    5,    0,   10,    4,     0,   1,  0};
    tbl[15] = '{3,    7,    1,   10,    4,     0,   0,  5};
    tbl[16] = '{3,    7,    1,   10,    4,     0,   0,  3};
    tbl[17] = '{3,    7,    1,   10,    4,     0,   0,  3};

    reset  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(posedge clk_50Mhz);
    #1;
    chk_all_zero("reset_state");
    $display("reset state period=%0d locked=%0d", period, locked);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) run_seg(i, tbl[i]);

    // Reset part-way through a period: outputs must clear before the next clock edge.
    sig_in = 1'b1;
    repeat (3) tick();
    sig_in = 1'b0;
    repeat (3) tick();
    chk("pre_reset_period", period, 10);
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    $display("async reset period=%0d expire=%0d locked=%0d", period, expire_est, locked);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    run_seg(100, '{5, 5, 0, 0, 0, 0, 0, 0});
    run_seg(101, '{5, 5, 1, 10, 4, 0, 0, 5});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
